// File: rtl/pid_pkg.sv
// Shared definitions for the PID sequencer: FSM states, config-select codes
// and a generic signed saturation helper.
package pid_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ERR,
        ST_PMUL,
        ST_IMUL,
        ST_DMUL,
        ST_OUT
    } pid_state_t;

    localparam logic [1:0] SEL_XSET = 2'b00;
    localparam logic [1:0] SEL_P    = 2'b01;
    localparam logic [1:0] SEL_I    = 2'b10;
    localparam logic [1:0] SEL_D    = 2'b11;

    // Clip x into the signed range of a w-bit word.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] x, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/pid_booth_mul.sv
// Sequential radix-2 Booth multiplier: signed CW-bit multiplier times DW-bit
// multiplicand, one Booth step per clock, done pulses once the product is held.
module pid_booth_mul #(
    parameter int DW = 14,
    parameter int CW = 14
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic signed [CW-1:0]     mplier,
    input  logic signed [DW-1:0]     mcand,
    output logic                     done,
    output logic signed [DW+CW+1:0]  prod
);
    localparam int AW = DW + 2;
    localparam int NW = (CW > 1) ? $clog2(CW) : 1;

    logic signed [AW-1:0] a_reg, m_reg, a_src, m_src, a_sum, a_next;
    logic [CW-1:0]        q_reg, q_src, q_next;
    logic                 q1_reg, q1_src, q1_next;
    logic [NW-1:0]        cnt_reg;
    logic                 run_reg, done_reg;

    // The start cycle already performs the first step from the fresh operands.
    always_comb begin
        if (start) begin
            a_src  = '0;
            q_src  = mplier;
            q1_src = 1'b0;
            m_src  = {{2{mcand[DW-1]}}, mcand};
        end else begin
            a_src  = a_reg;
            q_src  = q_reg;
            q1_src = q1_reg;
            m_src  = m_reg;
        end
        case ({q_src[0], q1_src})
            2'b01:   a_sum = a_src + m_src;
            2'b10:   a_sum = a_src - m_src;
            default: a_sum = a_src;
        endcase
        {a_next, q_next, q1_next} = {a_sum[AW-1], a_sum, q_src};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            m_reg    <= '0;
            q_reg    <= '0;
            q1_reg   <= 1'b0;
            cnt_reg  <= '0;
            run_reg  <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (start || run_reg) begin
                a_reg  <= a_next;
                q_reg  <= q_next;
                q1_reg <= q1_next;
            end
            if (start) begin
                m_reg    <= m_src;
                cnt_reg  <= NW'(1);
                run_reg  <= (CW > 1);
                done_reg <= (CW == 1);
            end else if (run_reg) begin
                cnt_reg <= cnt_reg + NW'(1);
                if (cnt_reg == NW'(CW - 1)) begin
                    run_reg  <= 1'b0;
                    done_reg <= 1'b1;
                end
            end
        end
    end

    assign done = done_reg;
    assign prod = {a_reg, q_reg};

endmodule

// File: rtl/pid_seq.sv
// Time-multiplexed PID controller; all channels share one Booth multiplier.
// Build option: define PID_ANTIWINDUP_EN to hold the integrator while saturated.
module pid_seq
    import pid_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int DW   = 14,
    parameter int CW   = 14,
    parameter int FRAC = 11,
    parameter int CHW  = (NCH > 1) ? $clog2(NCH) : 1,
    parameter int WW   = (DW > CW) ? DW : CW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 meas_vld,
    input  logic [CHW-1:0]       meas_ch,
    input  logic signed [DW-1:0] meas,
    input  logic                 cfg_we,
    input  logic [CHW-1:0]       cfg_ch,
    input  logic [1:0]           cfg_sel,
    input  logic [WW-1:0]        cfg_wdata,
    output logic                 busy,
    output logic                 duty_vld,
    output logic [CHW-1:0]       duty_ch,
    output logic signed [DW-1:0] duty,
    output logic                 sat
);
    localparam int AW = DW + CW + 2;

    pid_state_t state_reg;
    logic [CHW-1:0]        ch_reg;
    logic signed [DW-1:0]  meas_reg, err_reg, sum_reg, derr_reg;
    logic signed [CW-1:0]  p_snap_reg, i_snap_reg, d_snap_reg;
    logic signed [AW-1:0]  acc_reg, acc_next;
    logic                  kill_reg, start_reg, busy_reg, duty_vld_reg, sat_reg;
    logic [CHW-1:0]        duty_ch_reg;
    logic signed [DW-1:0]  duty_reg;

    logic signed [DW-1:0]  xset_rf [NCH];
    logic signed [DW-1:0]  sum_rf  [NCH];
    logic signed [DW-1:0]  prev_rf [NCH];
    logic signed [CW-1:0]  p_rf    [NCH];
    logic signed [CW-1:0]  i_rf    [NCH];
    logic signed [CW-1:0]  d_rf    [NCH];

    logic                  cfg_ok, meas_ok, accept, xset_wr;
    logic                  commit_prev, commit_sum, hold_sum, sat_n;
    logic signed [DW:0]    diff_w, sum_w, derr_w;
    logic signed [DW-1:0]  err_n, sumn_n, derr_n, clip_n;
    logic signed [CW-1:0]  mul_mplier;
    logic signed [DW-1:0]  mul_mcand;
    logic                  mul_done;
    logic signed [AW-1:0]  mul_prod;

    assign cfg_ok  = cfg_we && ({1'b0, cfg_ch} < (CHW + 1)'(NCH));
    assign meas_ok = ({1'b0, meas_ch} < (CHW + 1)'(NCH));
    assign accept  = meas_vld && meas_ok && (state_reg == ST_IDLE);
    assign xset_wr = cfg_ok && (cfg_sel == SEL_XSET);

    // Per-channel state; an XSET write wins over a same-cycle commit.
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic signed [DW-1:0] xset_reg, sum_err_reg, prev_err_reg;
        logic signed [CW-1:0] p_reg, i_reg, d_reg;
        logic                 wr;
        logic                 own;

        assign wr  = cfg_ok && (cfg_ch == CHW'(gi));
        assign own = (ch_reg == CHW'(gi));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                xset_reg     <= '0;
                sum_err_reg  <= '0;
                prev_err_reg <= '0;
                p_reg        <= '0;
                i_reg        <= '0;
                d_reg        <= '0;
            end else begin
                if (commit_sum && own) sum_err_reg <= sum_reg;
                if (commit_prev && own) prev_err_reg <= err_reg;
                if (wr) begin
                    case (cfg_sel)
                        SEL_XSET: begin
                            xset_reg     <= cfg_wdata[DW-1:0];
                            sum_err_reg  <= '0;
                            prev_err_reg <= '0;
                        end
                        SEL_P:   p_reg <= cfg_wdata[CW-1:0];
                        SEL_I:   i_reg <= cfg_wdata[CW-1:0];
                        default: d_reg <= cfg_wdata[CW-1:0];
                    endcase
                end
            end
        end

        assign xset_rf[gi] = xset_reg;
        assign sum_rf[gi]  = sum_err_reg;
        assign prev_rf[gi] = prev_err_reg;
        assign p_rf[gi]    = p_reg;
        assign i_rf[gi]    = i_reg;
        assign d_rf[gi]    = d_reg;
    end

    always_comb begin
        diff_w = {meas_reg[DW-1], meas_reg} - {xset_rf[ch_reg][DW-1], xset_rf[ch_reg]};
        err_n  = DW'(saturate(64'(diff_w), DW));
        sum_w  = {sum_rf[ch_reg][DW-1], sum_rf[ch_reg]} + {err_n[DW-1], err_n};
        sumn_n = DW'(saturate(64'(sum_w), DW));
        derr_w = {err_n[DW-1], err_n} - {prev_rf[ch_reg][DW-1], prev_rf[ch_reg]};
        derr_n = DW'(saturate(64'(derr_w), DW));
        clip_n = DW'(saturate(64'(acc_reg), DW));
        sat_n  = (64'(clip_n) != 64'(acc_reg));
    end

    always_comb begin
        case (state_reg)
            ST_PMUL: begin mul_mplier = p_snap_reg; mul_mcand = err_reg;  end
            ST_IMUL: begin mul_mplier = i_snap_reg; mul_mcand = sum_reg;  end
            default: begin mul_mplier = d_snap_reg; mul_mcand = derr_reg; end
        endcase
    end

    assign acc_next = acc_reg + (mul_prod >>> FRAC);

`ifdef PID_ANTIWINDUP_EN
    assign hold_sum = sat_n && (err_reg != '0) && (err_reg[DW-1] == acc_reg[AW-1]);
`else
    assign hold_sum = 1'b0;
`endif

    assign commit_prev = (state_reg == ST_OUT) && !kill_reg;
    assign commit_sum  = commit_prev && !hold_sum;

    pid_booth_mul #(.DW(DW), .CW(CW)) u_mul (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start_reg),
        .mplier (mul_mplier),
        .mcand  (mul_mcand),
        .done   (mul_done),
        .prod   (mul_prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            ch_reg       <= '0;
            meas_reg     <= '0;
            err_reg      <= '0;
            sum_reg      <= '0;
            derr_reg     <= '0;
            p_snap_reg   <= '0;
            i_snap_reg   <= '0;
            d_snap_reg   <= '0;
            acc_reg      <= '0;
            kill_reg     <= 1'b0;
            start_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            duty_vld_reg <= 1'b0;
            duty_reg     <= '0;
            duty_ch_reg  <= '0;
            sat_reg      <= 1'b0;
        end else begin
            duty_vld_reg <= 1'b0;
            start_reg    <= 1'b0;
            if (state_reg != ST_IDLE && xset_wr && cfg_ch == ch_reg) kill_reg <= 1'b1;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        ch_reg     <= meas_ch;
                        meas_reg   <= meas;
                        p_snap_reg <= p_rf[meas_ch];
                        i_snap_reg <= i_rf[meas_ch];
                        d_snap_reg <= d_rf[meas_ch];
                        kill_reg   <= xset_wr && (cfg_ch == meas_ch);
                        busy_reg   <= 1'b1;
                        state_reg  <= ST_ERR;
                    end
                end
                ST_ERR: begin
                    err_reg   <= err_n;
                    sum_reg   <= sumn_n;
                    derr_reg  <= derr_n;
                    acc_reg   <= '0;
                    start_reg <= 1'b1;
                    state_reg <= ST_PMUL;
                end
                ST_PMUL, ST_IMUL, ST_DMUL: begin
                    if (mul_done) begin
                        acc_reg   <= acc_next;
                        start_reg <= (state_reg != ST_DMUL);
                        state_reg <= (state_reg == ST_PMUL) ? ST_IMUL :
                                     (state_reg == ST_IMUL) ? ST_DMUL : ST_OUT;
                    end
                end
                default: begin
                    duty_vld_reg <= 1'b1;
                    duty_reg     <= clip_n;
                    sat_reg      <= sat_n;
                    duty_ch_reg  <= ch_reg;
                    busy_reg     <= 1'b0;
                    state_reg    <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_reg;
    assign duty_vld = duty_vld_reg;
    assign duty     = duty_reg;
    assign duty_ch  = duty_ch_reg;
    assign sat      = sat_reg;

endmodule

// File: tb/tb_pid_seq.sv
// Self-checking bench for pid_seq: directed scenarios plus randomized traffic
// compared against an arithmetic per-channel PID model.
module tb_pid_seq;
    localparam int NCH  = 4;
    localparam int DW   = 14;
    localparam int CW   = 14;
    localparam int FRAC = 11;
    localparam int CHW  = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 meas_vld = 1'b0;
    logic [CHW-1:0]       meas_ch = '0;
    logic signed [DW-1:0] meas = '0;
    logic                 cfg_we = 1'b0;
    logic [CHW-1:0]       cfg_ch = '0;
    logic [1:0]           cfg_sel = '0;
    logic [DW-1:0]        cfg_wdata = '0;
    logic                 busy, duty_vld, sat;
    logic [CHW-1:0]       duty_ch;
    logic signed [DW-1:0] duty;

    always #5 clk = ~clk;

    pid_seq #(.NCH(NCH), .DW(DW), .CW(CW), .FRAC(FRAC)) dut (
        .clk(clk), .rst_n(rst_n),
        .meas_vld(meas_vld), .meas_ch(meas_ch), .meas(meas),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata),
        .busy(busy), .duty_vld(duty_vld), .duty_ch(duty_ch), .duty(duty), .sat(sat)
    );

    int n_cmp = 0;
    int n_err = 0;
    int m_xset [NCH];
    int m_p    [NCH];
    int m_i    [NCH];
    int m_d    [NCH];
    int m_sum  [NCH];
    int m_prev [NCH];

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat14(input longint x);
        if (x > 8191) return 8191;
        if (x < -8192) return -8192;
        return int'(x);
    endfunction

    function automatic int sx14(input int v);
        int t;
        t = v & 32'h3FFF;
        if (t >= 8192) t -= 16384;
        return t;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            m_xset[k] = 0; m_p[k] = 0; m_i[k] = 0; m_d[k] = 0; m_sum[k] = 0; m_prev[k] = 0;
        end
    endtask

    task automatic model_cfg(input int ch, input int sel, input int v);
        case (sel)
            0: begin m_xset[ch] = sx14(v); m_sum[ch] = 0; m_prev[ch] = 0; end
            1: m_p[ch] = sx14(v);
            2: m_i[ch] = sx14(v);
            default: m_d[ch] = sx14(v);
        endcase
    endtask

    task automatic cfg_write(input int ch, input int sel, input int v);
        @(negedge clk);
        cfg_we = 1'b1; cfg_ch = CHW'(ch); cfg_sel = 2'(sel); cfg_wdata = DW'(v);
        @(negedge clk);
        cfg_we = 1'b0;
        model_cfg(ch, sel, v);
    endtask

    // One measurement transaction; optional config write 11 edges after accept
    // and optional extra strobes while busy that must be dropped.
    task automatic do_meas(input int ch, input int m, input bit mid_en, input int mid_ch,
                           input int mid_sel, input int mid_val, input bit drop_en,
                           output int got);
        int e, sn, de, ed, lat, extra;
        longint acc;
        bit es, kill, hold;
        e   = sat14(longint'(m) - m_xset[ch]);
        sn  = sat14(longint'(m_sum[ch]) + e);
        de  = sat14(longint'(e) - m_prev[ch]);
        acc = ((longint'(m_p[ch]) * e) >>> FRAC) + ((longint'(m_i[ch]) * sn) >>> FRAC)
            + ((longint'(m_d[ch]) * de) >>> FRAC);
        ed  = sat14(acc);
        es  = (longint'(ed) != acc);

        @(negedge clk);
        meas_vld = 1'b1; meas_ch = CHW'(ch); meas = DW'(m);
        @(negedge clk);
        meas_vld = 1'b0;
        check_eq("busy_after_accept", int'(busy), 1);
        lat = 0;
        while (duty_vld !== 1'b1 && lat < 200) begin
            cfg_we = mid_en && (lat == 10);
            if (mid_en && lat == 10) begin
                cfg_ch = CHW'(mid_ch); cfg_sel = 2'(mid_sel); cfg_wdata = DW'(mid_val);
            end
            meas_vld = drop_en && (lat == 4 || lat == 5);
            meas     = DW'(123);
            meas_ch  = (lat == 5) ? CHW'(5) : CHW'((ch + 2) % NCH);
            @(negedge clk);
            lat++;
        end
        cfg_we = 1'b0; meas_vld = 1'b0;
        check_eq("latency", lat, 47);
        check_eq("duty", int'(duty), ed);
        check_eq("duty_ch", int'(duty_ch), ch);
        check_eq("sat", int'(sat), int'(es));
        got = int'(duty);
        $display("txn ch=%0d meas=%0d duty=%0d sat=%0d lat=%0d", ch, m, got, sat, lat);
        @(negedge clk);
        check_eq("duty_vld_pulse", int'(duty_vld), 0);
        check_eq("duty_hold", int'(duty), ed);
        if (drop_en) begin
            extra = 0;
            for (int k = 0; k < 60; k++) begin
                @(negedge clk);
                if (duty_vld === 1'b1) extra++;
            end
            check_eq("dropped_extra_vld", extra, 0);
            check_eq("busy_after_drop", int'(busy), 0);
            check_eq("duty_hold_long", int'(duty), ed);
        end

        kill = mid_en && mid_sel == 0 && mid_ch == ch;
        hold = 1'b0;
`ifdef PID_ANTIWINDUP_EN
        hold = es && ((e > 0 && ed > 0) || (e < 0 && ed < 0));
`endif
        if (!kill) begin
            m_prev[ch] = e;
            if (!hold) m_sum[ch] = sn;
        end
        if (mid_en) model_cfg(mid_ch, mid_sel, mid_val);
    endtask

    initial begin
        int r, ch, m, nw;
        model_reset();
        #1 rst_n = 1'b0;
        #10;
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_duty_vld", int'(duty_vld), 0);
        check_eq("rst_duty", int'(duty), 0);
        check_eq("rst_duty_ch", int'(duty_ch), 0);
        check_eq("rst_sat", int'(sat), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Proportional only, unity gain on ch0
        cfg_write(0, 0, 0);
        cfg_write(0, 1, 'h800);
        do_meas(0, 100, 0, 0, 0, 0, 0, r); check_eq("p_100", r, 100);
        do_meas(0, -5, 0, 0, 0, 0, 0, r);  check_eq("p_m5", r, -5);

        // Integral accumulation on ch1
        cfg_write(1, 0, 10);
        cfg_write(1, 2, 'h800);
        do_meas(1, 20, 0, 0, 0, 0, 0, r); check_eq("i_1", r, 10);
        do_meas(1, 20, 0, 0, 0, 0, 0, r); check_eq("i_2", r, 20);
        do_meas(1, 20, 0, 0, 0, 0, 0, r); check_eq("i_3", r, 30);

        // Derivative, half gain on ch2
        cfg_write(2, 3, 'h400);
        do_meas(2, 0, 0, 0, 0, 0, 0, r);  check_eq("d_0", r, 0);
        do_meas(2, 40, 0, 0, 0, 0, 0, r); check_eq("d_40", r, 20);

        // Saturation on ch3, then expose the integrator contents with P=0
        cfg_write(3, 1, 'h1FFF);
        cfg_write(3, 0, 'h2000);
        do_meas(3, 8191, 0, 0, 0, 0, 0, r); check_eq("sat_duty", r, 8191);
        check_eq("sat_flag", int'(sat), 1);
        cfg_write(3, 2, 'h800);
        do_meas(3, 8191, 0, 0, 0, 0, 0, r);
        do_meas(3, 8191, 0, 0, 0, 0, 0, r);
        cfg_write(3, 1, 0);
        do_meas(3, -8192, 0, 0, 0, 0, 0, r);
`ifdef PID_ANTIWINDUP_EN
        check_eq("windup_sum", r, 0);
`else
        check_eq("windup_sum", r, 8191);
`endif

        // Strobes while busy are dropped
        do_meas(0, 77, 0, 0, 0, 0, 1, r); check_eq("drop_duty", r, 77);

        // XSET during ch1 computation suppresses its commit
        do_meas(1, 20, 1, 1, 0, 10, 0, r); check_eq("xset_inflight", r, 40);
        do_meas(1, 20, 0, 0, 0, 0, 0, r);  check_eq("xset_after", r, 10);

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            nw = $urandom_range(0, 2);
            for (int w = 0; w < nw; w++) begin
                int sel;
                sel = $urandom_range(0, 3);
                if (sel == 0) cfg_write($urandom_range(0, 3), 0, $urandom_range(0, 16383));
                else cfg_write($urandom_range(0, 3), sel, $urandom_range(0, 4095) - 2048);
            end
            ch = $urandom_range(0, 3);
            m  = int'($urandom_range(0, 16383)) - 8192;
            if ($urandom_range(0, 3) == 0)
                do_meas(ch, m, 1, $urandom_range(0, 3), $urandom_range(0, 3),
                        $urandom_range(0, 4095), 0, r);
            else
                do_meas(ch, m, 0, 0, 0, 0, 0, r);
        end

        // Reset in the middle of a computation
        cfg_write(0, 1, 'h800);
        cfg_write(0, 0, 0);
        @(negedge clk);
        meas_vld = 1'b1; meas_ch = '0; meas = DW'(-300);
        @(negedge clk);
        meas_vld = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_busy", int'(busy), 0);
        check_eq("mid_rst_duty_vld", int'(duty_vld), 0);
        check_eq("mid_rst_duty", int'(duty), 0);
        check_eq("mid_rst_sat", int'(sat), 0);
        rst_n = 1'b1;
        model_reset();
        nw = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (duty_vld === 1'b1) nw++;
        end
        check_eq("mid_rst_no_vld", nw, 0);
        do_meas(0, 100, 0, 0, 0, 0, 0, r); check_eq("post_rst_cfg_clear", r, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
